imem_loader: RTL and testbench

//  Writer side of the instruction memory: streams 9-bit instruction words from a

---
 rtl/imem_loader_if.sv | 15 +
 rtl/imem_loader.sv | 66 ++++++
 tb/tb_imem_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: host word stream in, instruction-memory write port out
interface imem_loader_if #(
    parameter int IW = 9,
    parameter int AW = 8
) ();
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    modport master (output in_valid, in_data, in_last, input in_ready, wr_en, wr_addr, wr_data);
    modport slave  (input in_valid, in_data, in_last, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams host words into instruction memory, appends the end marker, gates core reset
module imem_loader #(
    parameter int            IW       = 9,
    parameter int            AW       = 8,
    parameter int            DEPTH    = 256,
    parameter logic [IW-1:0] END_WORD = 9'h1FF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          overflow_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] TERM  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    logic [2:0] state;
    logic       accept, last_slot, restart;

    assign bus.in_ready = state == LOAD;
    assign overflow_err = state == ERROR;
    assign accept       = bus.in_valid && bus.in_ready;
    // word_count doubles as the write pointer: both start at 0 and advance together
    assign last_slot    = word_count == (AW+1)'(DEPTH-2);
    assign restart      = start && (state == IDLE || state == RUN || state == ERROR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            cpu_reset   <= 1'b1;
            load_done   <= 1'b0;
            word_count  <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            // release lags entry to RUN by a cycle so the marker write lands with the core still held
            cpu_reset <= !(state == RUN && !start);
            load_done <= state == RUN && !start;
            if (restart) begin
                state      <= LOAD;
                word_count <= '0;
            end else if (accept) begin
                word_count <= word_count + 1'b1;
                state      <= bus.in_last ? TERM : last_slot ? ERROR : LOAD;
                if (bus.in_last || !last_slot) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= word_count[AW-1:0];
                    bus.wr_data <= bus.in_data;
                end
            end else if (state == TERM) begin
                state       <= RUN;
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= word_count[AW-1:0];
                bus.wr_data <= END_WORD;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against an image-level model of the expected memory writes
module tb_imem_loader;
    localparam logic [8:0] END = 9'h1FF;

    logic       clk = 0;
    logic       reset = 0;
    logic       start = 0;
    logic       cpu_reset, load_done, overflow_err;
    logic [8:0] word_count;
    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0]  img [0:255];
    logic [16:0] obs [$];
    logic        acc_prev = 0;

    imem_loader_if #(.IW(9), .AW(8)) bus ();

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .cpu_reset(cpu_reset), .load_done(load_done),
        .word_count(word_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // every write must hit while the core is held, and data writes follow an accept by one cycle
    always @(negedge clk) begin
        if (bus.wr_en) begin
            obs.push_back({bus.wr_addr, bus.wr_data});
            chk("core_held", 32'(cpu_reset), 1);
            if (bus.wr_data != END) chk("write_latency", 32'(acc_prev), 1);
        end
        acc_prev = bus.in_valid && bus.in_ready && reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        obs.delete();
        start = 1;
        step();
        start = 0;
        chk("restart_ovf", 32'(overflow_err), 0);
        chk("restart_cpurst", 32'(cpu_reset), 1);
        chk("restart_done", 32'(load_done), 0);
        chk("restart_wc", 32'(word_count), 0);
    endtask

    task automatic send(input logic [8:0] w, input bit last, input int gap);
        int k = 0;
        repeat (gap) step();
        bus.in_valid = 1;
        bus.in_data  = w;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (++k > 20) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
        step();
        bus.in_valid = 0;
        bus.in_last  = 0;
    endtask

    task automatic load(input int n, input bit term, input int gap);
        logic [16:0] exp [$];
        pulse_start();
        for (int i = 0; i < n; i++)
            send(img[i], term && i == n - 1, gap < 0 ? int'($urandom_range(0, 3)) : gap);
        repeat (4) step();
        for (int i = 0; i < n; i++)
            if (term || i < 254) exp.push_back({8'(i), img[i]});
        if (term) exp.push_back({8'(n), END});
        chk("n_writes", obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++) chk("write", 32'(obs[i]), 32'(exp[i]));
        chk("word_count", 32'(word_count), term ? n : 255);
        chk("load_done", 32'(load_done), 32'(term));
        chk("cpu_reset", 32'(cpu_reset), 32'(!term));
        chk("overflow", 32'(overflow_err), 32'(!term));
        chk("ready_idle", 32'(bus.in_ready), 0);
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) img[i] = 9'($urandom_range(0, 'h1FE));
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data  = '0;
        bus.in_last  = 0;
        repeat (2) step();
        chk("rst_cpurst", 32'(cpu_reset), 1);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_wren", 32'(bus.wr_en), 0);
        chk("rst_addr", 32'(bus.wr_addr), 0);
        chk("rst_data", 32'(bus.wr_data), 0);
        chk("rst_wc", 32'(word_count), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        reset = 1;
        step();
        img[0] = 9'h011; img[1] = 9'h0A2; img[2] = 9'h133;
        load(3, 1, 0);
        load(3, 1, 2);
        fill();
        load(255, 0, 0);
        fill();
        pulse_start();
        send(img[0], 0, 0);
        send(img[1], 0, 0);
        reset = 0;
        step();
        chk("midrst_cpurst", 32'(cpu_reset), 1);
        chk("midrst_ready", 32'(bus.in_ready), 0);
        chk("midrst_wren", 32'(bus.wr_en), 0);
        chk("midrst_addr", 32'(bus.wr_addr), 0);
        chk("midrst_wc", 32'(word_count), 0);
        reset = 1;
        step();
        load(4, 1, -1);
        img[0] = 9'h005;
        load(1, 1, 0);
        for (int r = 0; r < 6; r++) begin
            fill();
            load(int'($urandom_range(1, 20)), 1, -1);
        end
        fill();
        load(255, 1, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
